// File: rtl/lif_neuron_multi_if.sv
// Bus bundle for lif_neuron_multi.
// master: drives step enable, spikes and weight writes; samples neuron outputs.
// slave : the neuron itself.
//   en      step enable
//   spk_in  one spike bit per synapse
//   w_wr    weight write strobe; w_addr / w_data select index and signed value
//   spike   one-cycle fire pulse
//   v_mem   membrane potential
//   refr    refractory indicator
//   led0    stretched spike indicator
interface lif_neuron_multi_if #(
  parameter int unsigned N_IN = 4,
  parameter int unsigned V_W  = 32,
  parameter int unsigned W_W  = 8
);
  localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                  en;
  logic [N_IN-1:0]       spk_in;
  logic                  w_wr;
  logic [AW-1:0]         w_addr;
  logic signed [W_W-1:0] w_data;
  logic                  spike;
  logic [V_W-1:0]        v_mem;
  logic                  refr;
  logic                  led0;

  modport master (
    output en, spk_in, w_wr, w_addr, w_data,
    input  spike, v_mem, refr, led0
  );

  modport slave (
    input  en, spk_in, w_wr, w_addr, w_data,
    output spike, v_mem, refr, led0
  );
endinterface

// File: rtl/lif_neuron_multi.sv
// Leaky integrate-and-fire neuron with N_IN weighted spike inputs.
// Leak is v >> LEAK_SHIFT per enabled step; membrane saturates to
// [0, 2^(V_W-1)-1]; crossing V_TH emits a one-cycle spike, resets the
// membrane to V_RST and holds it there for T_REF enabled steps.
// led0 stretches each spike over LED_HOLD free-running cycles.
// Ports: clk, rst (sync, active-high), bus (lif_neuron_multi_if.slave).
// All outputs come straight from flops.
module lif_neuron_multi #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned V_W        = 32,
  parameter int unsigned W_W        = 8,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned V_TH       = 1000,
  parameter int unsigned V_RST      = 0,
  parameter int unsigned T_REF      = 5,
  parameter int unsigned LED_HOLD   = 4
) (
  input  logic               clk,
  input  logic               rst,
  lif_neuron_multi_if.slave  bus
);

  localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  // Wide enough that v + sum of N_IN weights never wraps before clamping.
  localparam int unsigned SW = V_W + W_W + AW + 1;
  localparam int unsigned RW = (T_REF > 0) ? $clog2(T_REF + 1) : 1;
  localparam int unsigned LW = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;

  localparam logic signed [SW-1:0] V_CEIL = SW'({1'b0, {(V_W-1){1'b1}}});
  localparam logic signed [SW-1:0] V_TH_S = SW'(V_TH);

  logic [V_W-1:0]        v_q,       v_d;
  logic                  spike_q,   spike_d;
  logic                  refr_q,    refr_d;
  logic                  led0_q,    led0_d;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [LW-1:0]         led_cnt_q, led_cnt_d;
  logic signed [W_W-1:0] w_q [N_IN];
  logic signed [W_W-1:0] w_d [N_IN];

  logic signed [SW-1:0]  i_sum;
  logic signed [SW-1:0]  v_ext;
  logic signed [SW-1:0]  v_raw;
  logic signed [SW-1:0]  v_clamp;

  // Synaptic current, leak and saturation for the current step.
  always_comb begin
    i_sum = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (bus.spk_in[i]) begin
        i_sum = i_sum + SW'(w_q[i]);
      end
    end
    v_ext = SW'(v_q);
    v_raw = v_ext - (v_ext >>> LEAK_SHIFT) + i_sum;
    if (v_raw < 0) begin
      v_clamp = '0;
    end else if (v_raw > V_CEIL) begin
      v_clamp = V_CEIL;
    end else begin
      v_clamp = v_raw;
    end
  end

  // Next-state: refractory countdown, fire decision, LED stretch, weight writes.
  always_comb begin
    v_d       = v_q;
    spike_d   = 1'b0;
    ref_cnt_d = ref_cnt_q;
    led_cnt_d = (led_cnt_q != '0) ? led_cnt_q - LW'(1) : led_cnt_q;
    for (int i = 0; i < int'(N_IN); i++) begin
      w_d[i] = w_q[i];
    end

    if (bus.en) begin
      if (ref_cnt_q != '0) begin
        // Refractory step: inputs ignored, membrane pinned at rest.
        ref_cnt_d = ref_cnt_q - RW'(1);
        v_d       = V_W'(V_RST);
      end else if (v_clamp >= V_TH_S) begin
        v_d       = V_W'(V_RST);
        spike_d   = 1'b1;
        ref_cnt_d = RW'(T_REF);
        led_cnt_d = LW'(LED_HOLD);
      end else begin
        v_d = V_W'(v_clamp);
      end
    end

    // Written weight takes effect from the next step.
    if (bus.w_wr && (32'(bus.w_addr) < N_IN)) begin
      w_d[bus.w_addr] = bus.w_data;
    end

    refr_d = (ref_cnt_d != '0);
    led0_d = (led_cnt_d != '0);
  end

  // State registers; reset also restores unit weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      spike_q   <= 1'b0;
      refr_q    <= 1'b0;
      led0_q    <= 1'b0;
      ref_cnt_q <= '0;
      led_cnt_q <= '0;
      for (int i = 0; i < int'(N_IN); i++) begin
        w_q[i] <= W_W'(1);
      end
    end else begin
      v_q       <= v_d;
      spike_q   <= spike_d;
      refr_q    <= refr_d;
      led0_q    <= led0_d;
      ref_cnt_q <= ref_cnt_d;
      led_cnt_q <= led_cnt_d;
      for (int i = 0; i < int'(N_IN); i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign bus.spike = spike_q;
  assign bus.v_mem = v_q;
  assign bus.refr  = refr_q;
  assign bus.led0  = led0_q;

endmodule

// File: tb/tb_lif_neuron_multi.sv
// Bench for lif_neuron_multi: main instance (V_TH=100, LEAK_SHIFT=4, T_REF=3)
// tracked by a reference model feeding a scoreboard queue; a narrow instance
// (V_W=10, V_TH=600) covers ceiling saturation.
module tb_lif_neuron_multi;

  logic clk;
  logic rst;

  lif_neuron_multi_if #(.N_IN(4), .V_W(32), .W_W(8)) nb ();
  lif_neuron_multi_if #(.N_IN(4), .V_W(10), .W_W(8)) pb ();

  lif_neuron_multi #(
    .N_IN(4), .V_W(32), .W_W(8), .LEAK_SHIFT(4), .V_TH(100),
    .V_RST(0), .T_REF(3), .LED_HOLD(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (nb)
  );

  lif_neuron_multi #(
    .N_IN(4), .V_W(10), .W_W(8), .LEAK_SHIFT(4), .V_TH(600),
    .V_RST(0), .T_REF(3), .LED_HOLD(4)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {v_mem, spike, refr, led0}
  typedef logic [34:0] exp_t;
  exp_t sb_q[$];

  longint m_v;
  int     m_ref;
  int     m_led;
  int     m_w[4];

  function automatic exp_t observed();
    return {nb.v_mem, nb.spike, nb.refr, nb.led0};
  endfunction

  task automatic model_reset();
    m_v = 0; m_ref = 0; m_led = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 1;
  endtask

  // Drive one cycle on the main instance and push its expected outcome.
  task automatic drive_step(input logic en, input logic [3:0] spk, input logic wr,
                            input logic [1:0] addr, input int data);
    longint cur, nv;
    bit sp;
    bit fire;
    sp = 1'b0; fire = 1'b0;
    if (en) begin
      if (m_ref != 0) begin
        m_ref = m_ref - 1;
        m_v   = 0;
      end else begin
        cur = 0;
        for (int i = 0; i < 4; i++) if (spk[i]) cur += m_w[i];
        nv = m_v - (m_v / 16) + cur;
        if (nv < 0) nv = 0;
        if (nv > 64'sd2147483647) nv = 64'sd2147483647;
        if (nv >= 100) begin
          m_v = 0; sp = 1'b1; m_ref = 3; fire = 1'b1;
        end else begin
          m_v = nv;
        end
      end
    end
    if (fire) m_led = 4;
    else if (m_led > 0) m_led = m_led - 1;
    if (wr) m_w[addr] = data;
    sb_q.push_back({32'(m_v), sp, (m_ref != 0), (m_led != 0)});

    nb.en     = en;
    nb.spk_in = spk;
    nb.w_wr   = wr;
    nb.w_addr = addr;
    nb.w_data = 8'(data);
    @(posedge clk);
    #1;
    nb.w_wr = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    nb.en = 1'b0; nb.spk_in = '0; nb.w_wr = 1'b0; nb.w_addr = '0; nb.w_data = '0;
    pb.en = 1'b0; pb.spk_in = '0; pb.w_wr = 1'b0; pb.w_addr = '0; pb.w_data = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t e, o;
    do_reset(2);
    checks++;
    o = observed();
    if (o !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", o, 35'd0);
    end
    for (int k = 0; k < 6; k++) begin
      drive_step(1'b1, 4'b0001, 1'b0, 2'd0, 0);
      e = sb_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL unit_weight_step%0d got=%h want=%h", k, o, e);
      end
      if (k < 2) begin
        checks++;
        if (nb.v_mem !== 32'(k + 1)) begin
          errors++;
          $display("FAIL unit_weight_v%0d got=%0d want=%0d", k, nb.v_mem, k + 1);
        end
      end
    end
  endtask

  task automatic test_fire_refract();
    exp_t e, o;
    do_reset(1);
    drive_step(1'b0, 4'b0000, 1'b1, 2'd0, 50);
    void'(sb_q.pop_front());
    for (int k = 0; k < 9; k++) begin
      drive_step(1'b1, 4'b0001, 1'b0, 2'd0, 0);
      e = sb_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fire_sb_step%0d got=%h want=%h", k, o, e);
      end
      case (k)
        0: begin checks++; if (nb.v_mem !== 32'd50) begin errors++; $display("FAIL fire_v50 got=%0d want=50", nb.v_mem); end end
        1: begin checks++; if (nb.v_mem !== 32'd97) begin errors++; $display("FAIL fire_v97 got=%0d want=97", nb.v_mem); end end
        2: begin checks++; if ({nb.spike, nb.v_mem, nb.refr, nb.led0} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
             errors++; $display("FAIL fire_pulse got spike=%b v=%0d refr=%b led=%b want 1 0 1 1", nb.spike, nb.v_mem, nb.refr, nb.led0); end end
        3, 4: begin checks++; if ({nb.spike, nb.v_mem, nb.refr} !== {1'b0, 32'd0, 1'b1}) begin
             errors++; $display("FAIL refract%0d got spike=%b v=%0d refr=%b want 0 0 1", k, nb.spike, nb.v_mem, nb.refr); end end
        5: begin checks++; if ({nb.v_mem, nb.refr, nb.led0} !== {32'd0, 1'b0, 1'b1}) begin
             errors++; $display("FAIL refract_end got v=%0d refr=%b led=%b want 0 0 1", nb.v_mem, nb.refr, nb.led0); end end
        6: begin checks++; if ({nb.v_mem, nb.led0} !== {32'd50, 1'b0}) begin
             errors++; $display("FAIL resume got v=%0d led=%b want 50 0", nb.v_mem, nb.led0); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_floor_clamp();
    exp_t e, o;
    do_reset(1);
    drive_step(1'b0, 4'b0000, 1'b1, 2'd1, -20);
    void'(sb_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      drive_step(1'b1, 4'b0010, 1'b0, 2'd0, 0);
      e = sb_q.pop_front();
      o = observed();
      checks++;
      if (o !== e || nb.v_mem !== 32'd0 || nb.spike !== 1'b0) begin
        errors++;
        $display("FAIL floor_clamp%0d got=%h want=%h", k, o, e);
      end
    end
  endtask

  task automatic test_ceiling();
    int v_exp;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      pb.w_wr = 1'b1; pb.w_addr = 2'(i); pb.w_data = 8'sd127;
      @(posedge clk); #1;
    end
    pb.w_wr = 1'b0;
    v_exp = 0;
    for (int k = 0; k < 10; k++) begin
      pb.en = 1'b1; pb.spk_in = 4'b1111;
      v_exp = v_exp - (v_exp / 16) + 508;
      if (v_exp > 511) v_exp = 511;
      @(posedge clk); #1;
      checks++;
      if (pb.v_mem !== 10'(v_exp) || pb.spike !== 1'b0) begin
        errors++;
        $display("FAIL ceiling%0d got v=%0d spike=%b want v=%0d spike=0", k, pb.v_mem, pb.spike, v_exp);
      end
    end
    pb.en = 1'b0; pb.spk_in = '0;
  endtask

  task automatic test_freeze_and_reset();
    exp_t e, o;
    do_reset(1);
    drive_step(1'b0, 4'b0000, 1'b1, 2'd0, 50);
    void'(sb_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      drive_step(1'b1, 4'b0001, 1'b0, 2'd0, 0);
      void'(sb_q.pop_front());
    end
    for (int k = 0; k < 5; k++) begin
      drive_step(1'b0, 4'b0001, 1'b0, 2'd0, 0);
      e = sb_q.pop_front();
      o = observed();
      checks++;
      if (o !== e || nb.refr !== 1'b1 || nb.v_mem !== 32'd0 || nb.spike !== 1'b0) begin
        errors++;
        $display("FAIL freeze%0d got=%h want=%h", k, o, e);
      end
    end
    do_reset(1);
    checks++;
    o = observed();
    if (o !== 35'd0) begin
      errors++;
      $display("FAIL mid_refract_reset got=%h want=%h", o, 35'd0);
    end
    drive_step(1'b1, 4'b0001, 1'b0, 2'd0, 0);
    e = sb_q.pop_front();
    checks++;
    if (nb.v_mem !== 32'd1 || observed() !== e) begin
      errors++;
      $display("FAIL weights_restored got v=%0d want v=1", nb.v_mem);
    end
  endtask

  task automatic test_write_collision();
    exp_t e, o;
    do_reset(1);
    drive_step(1'b0, 4'b0000, 1'b1, 2'd0, 50);
    void'(sb_q.pop_front());
    drive_step(1'b1, 4'b0001, 1'b1, 2'd0, 10);
    e = sb_q.pop_front();
    o = observed();
    checks++;
    if (o !== e || nb.v_mem !== 32'd50) begin
      errors++;
      $display("FAIL old_weight got v=%0d want v=50", nb.v_mem);
    end
    drive_step(1'b1, 4'b0001, 1'b0, 2'd0, 0);
    e = sb_q.pop_front();
    o = observed();
    checks++;
    if (o !== e || nb.v_mem !== 32'd57) begin
      errors++;
      $display("FAIL new_weight got v=%0d want v=57", nb.v_mem);
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_fire_refract();
    test_floor_clamp();
    test_ceiling();
    test_freeze_and_reset();
    test_write_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
